// File: rtl/rv32m_div.sv
// rv32m_div: iterative RV32M divider (DIV/DIVU/REM/REMU).
// One restoring-division step per cycle on operand magnitudes, with the
// sign fix-up applied as the last step retires. Divide-by-zero and signed
// overflow can optionally skip the iteration entirely (EARLY_OUT).
module rv32m_div #(
  parameter int EARLY_OUT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs1val,
  input  logic [31:0] rs2val,
  input  logic [4:0]  rd_in,
  input  logic        kill,
  output logic        busy,
  output logic [4:0]  rd,
  output logic [31:0] rrd,
  output logic        we
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic        rem_q;   // 1 = REM/REMU result wanted
  logic        sa_q;    // dividend negative (signed ops only)
  logic        sb_q;    // divisor negative (signed ops only)
  logic        dz_q;    // divisor was zero
  logic [4:0]  rd_q;
  logic [31:0] dvs;     // divisor magnitude
  logic [31:0] quo;     // dividend bits shifting out, quotient bits shifting in
  logic [31:0] prem;    // partial remainder

  // Operand decode at acceptance
  logic        signed_op, a_neg, b_neg, dz, ovf;
  logic [31:0] a_mag, b_mag, early_res;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & rs1val[31];
  assign b_neg     = signed_op & rs2val[31];
  assign a_mag     = a_neg ? -rs1val : rs1val;
  assign b_mag     = b_neg ? -rs2val : rs2val;
  assign dz        = (rs2val == 32'd0);
  assign ovf       = signed_op && (rs1val == 32'h8000_0000) && (rs2val == 32'hFFFF_FFFF);
  assign early_res = dz ? (op[1] ? rs1val : 32'hFFFF_FFFF)
                        : (op[1] ? 32'd0  : 32'h8000_0000);

  // Restoring step: shift remainder left, trial-subtract, set quotient bit
  logic [32:0] rem_sh, diff;
  logic        q_bit;
  logic [31:0] rem_nx, quo_nx;

  assign rem_sh = {prem, quo[31]};
  assign diff   = rem_sh - {1'b0, dvs};
  assign q_bit  = ~diff[32];
  assign rem_nx = q_bit ? diff[31:0] : rem_sh[31:0];
  assign quo_nx = {quo[30:0], q_bit};

  // Sign fix-up; a zero divisor keeps the all-ones quotient un-negated
  logic        q_neg;
  logic [31:0] q_res, r_res, res;

  assign q_neg = (sa_q ^ sb_q) & ~dz_q;
  assign q_res = q_neg ? -quo_nx : quo_nx;
  assign r_res = sa_q ? -rem_nx : rem_nx;
  assign res   = rem_q ? r_res : q_res;

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 6'd0;
      rem_q <= 1'b0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      dz_q  <= 1'b0;
      rd_q  <= 5'd0;
      dvs   <= 32'd0;
      quo   <= 32'd0;
      prem  <= 32'd0;
      rd    <= 5'd0;
      rrd   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !kill) begin
            rem_q <= op[1];
            sa_q  <= a_neg;
            sb_q  <= b_neg;
            dz_q  <= dz;
            rd_q  <= rd_in;
            dvs   <= b_mag;
            quo   <= a_mag;
            prem  <= 32'd0;
            cnt   <= 6'd0;
            if ((EARLY_OUT != 0) && (dz || ovf)) begin
              state <= DONE;
              rd    <= rd_in;
              rrd   <= early_res;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (kill) begin
            state <= IDLE;
          end else begin
            prem <= rem_nx;
            quo  <= quo_nx;
            cnt  <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              state <= DONE;
              rd    <= rd_q;
              rrd   <= res;
            end
          end
        end
        default: state <= IDLE;  // DONE lasts one cycle; kill lands here too
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign we   = (state == DONE) && (rd != 5'd0);

endmodule

// File: tb/tb_rv32m_div.sv
// tb_rv32m_div: directed checks of rv32m_div, with early-out enabled (u0)
// and disabled (u1) driven by the same stimulus side by side.
module tb_rv32m_div;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [1:0]  op;
  logic [31:0] rs1val, rs2val;
  logic [4:0]  rd_in;
  logic        busy0, we0, busy1, we1;
  logic [4:0]  rd0, rd1;
  logic [31:0] rrd0, rrd1;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  rv32m_div #(.EARLY_OUT(1)) u0 (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1val(rs1val),
    .rs2val(rs2val), .rd_in(rd_in), .kill(kill), .busy(busy0), .rd(rd0),
    .rrd(rrd0), .we(we0)
  );

  rv32m_div #(.EARLY_OUT(0)) u1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1val(rs1val),
    .rs2val(rs2val), .rd_in(rd_in), .kill(kill), .busy(busy1), .rd(rd1),
    .rrd(rrd1), .we(we1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, follow both DUTs until idle (bounded), then check.
  // lat0 is the expected edge count (acceptance edge = 1) of u0's we.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r,
                       input logic [31:0] exp, input int lat0, input bit disturb);
    int n0 = 0, n1 = 0, w0 = 0, w1 = 0, b0 = 0, b1 = 0;
    logic [31:0] v0 = 32'd0, v1 = 32'd0;
    logic [4:0]  d0 = 5'd0;
    op = o; rs1val = a; rs2val = b; rd_in = r; start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (we0) begin w0++; if (n0 == 0) begin n0 = n; v0 = rrd0; d0 = rd0; end end
      if (we1) begin w1++; if (n1 == 0) begin n1 = n; v1 = rrd1; end end
      if (busy0) b0++;
      if (busy1) b1++;
      if (disturb && n == 5) begin
        start = 1'b1; op = 2'b11; rs1val = 32'h1234; rs2val = 32'd3; rd_in = 5'd9;
      end else if (disturb && n == 6) begin
        start = 1'b0;
      end
      if (!busy0 && !busy1) break;
      step();
    end
    if (r != 5'd0) begin
      chk({tag, "_lat0"}, n0, lat0);
      chk({tag, "_rrd0"}, v0, exp);
      chk({tag, "_rd0"},  {27'd0, d0}, {27'd0, r});
      chk({tag, "_we0n"}, w0, 1);
      chk({tag, "_lat1"}, n1, 33);
      chk({tag, "_rrd1"}, v1, exp);
    end else begin
      chk({tag, "_we0n"},  w0, 0);
      chk({tag, "_we1n"},  w1, 0);
      chk({tag, "_busy0"}, b0, 33);
      chk({tag, "_busy1"}, b1, 33);
    end
  endtask

  initial begin
    int wc;
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = 2'b00;
    rs1val = 32'd0; rs2val = 32'd0; rd_in = 5'd0;
    step(); step();
    chk("rst_busy0", {31'd0, busy0}, 0);
    chk("rst_we0",   {31'd0, we0},   0);
    chk("rst_rd0",   {27'd0, rd0},   0);
    chk("rst_rrd0",  rrd0,           0);
    chk("rst_busy1", {31'd0, busy1}, 0);
    rst = 1'b0;

    // Basic unsigned / signed division
    do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd1, 32'd14, 33, 1'b0);
    do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd2, 32'd2,  33, 1'b0);
    do_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 33, 1'b0);
    do_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, 33, 1'b0);
    do_op("div_7_m3",   2'b00, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFFE, 33, 1'b0);
    do_op("rem_7_m3",   2'b10, 32'd7, 32'hFFFF_FFFD, 5'd6, 32'd1, 33, 1'b0);
    do_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 5'd7, 32'hFFFF_FFFF, 33, 1'b0);

    // Divide by zero and signed overflow
    do_op("divu_5_0",   2'b01, 32'd5, 32'd0, 5'd8,  32'hFFFF_FFFF, 1, 1'b0);
    do_op("remu_5_0",   2'b11, 32'd5, 32'd0, 5'd9,  32'd5, 1, 1'b0);
    do_op("div_m5_0",   2'b00, 32'hFFFF_FFFB, 32'd0, 5'd10, 32'hFFFF_FFFF, 1, 1'b0);
    do_op("rem_m5_0",   2'b10, 32'hFFFF_FFFB, 32'd0, 5'd11, 32'hFFFF_FFFB, 1, 1'b0);
    do_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1, 1'b0);
    do_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 1, 1'b0);

    // rd=0: full sequence, never writes
    do_op("rd0_divu",   2'b01, 32'd9, 32'd3, 5'd0, 32'd3, 33, 1'b0);

    // Start during RUN plus operand changes after acceptance are ignored
    do_op("busy_start", 2'b01, 32'd100, 32'd7, 5'd14, 32'd14, 33, 1'b1);

    // Kill at RUN cycle 10
    op = 2'b01; rs1val = 32'd100; rs2val = 32'd7; rd_in = 5'd15; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill_busy0", {31'd0, busy0}, 0);
    chk("kill_busy1", {31'd0, busy1}, 0);
    wc = 0;
    for (int i = 0; i < 30; i++) begin
      if (we0 || we1) wc++;
      step();
    end
    chk("kill_no_we", wc, 0);
    do_op("after_kill", 2'b10, 32'd100, 32'd7, 5'd16, 32'd2, 33, 1'b0);

    // Kill in IDLE blocks start
    op = 2'b01; rs1val = 32'd8; rs2val = 32'd2; rd_in = 5'd17; start = 1'b1; kill = 1'b1;
    step();
    start = 1'b0; kill = 1'b0;
    chk("kill_idle_busy0", {31'd0, busy0}, 0);
    chk("kill_idle_busy1", {31'd0, busy1}, 0);

    // Reset mid-RUN clears everything; next start accepted right away
    op = 2'b01; rs1val = 32'd100; rs2val = 32'd7; rd_in = 5'd18; start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy0", {31'd0, busy0}, 0);
    chk("mid_rst_busy1", {31'd0, busy1}, 0);
    chk("mid_rst_rd0",   {27'd0, rd0},   0);
    chk("mid_rst_rrd0",  rrd0,           0);
    do_op("after_rst", 2'b00, 32'd1000, 32'hFFFF_FFF6, 5'd19, 32'hFFFF_FF9C, 33, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
